// File: rtl/cpu_debug_pkg.sv
// Shared definitions for the CPU debug sequencer: command op codes,
// sequencer states, observation select indices and the snapshot payload.
package cpu_debug_pkg;

   localparam int unsigned OP_W   = 2;
   localparam int unsigned PC_W   = 8;
   localparam int unsigned SEL_W  = 8;
   localparam int unsigned DATA_W = 32;

   // Host command op codes
   localparam logic [OP_W-1:0] OP_STEP      = 2'b00;
   localparam logic [OP_W-1:0] OP_LOAD      = 2'b01;
   localparam logic [OP_W-1:0] OP_SNAP      = 2'b10;
   localparam logic [OP_W-1:0] OP_STEP_SNAP = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_PULSE_HI   = 3'd1,
      ST_PULSE_LO   = 3'd2,
      ST_SEL_SETTLE = 3'd3,
      ST_EMIT       = 3'd4
   } state_t;

   // CPU observation select indices
   localparam logic [SEL_W-1:0] SEL_INSTR  = 8'd0;
   localparam logic [SEL_W-1:0] SEL_RS     = 8'd1;
   localparam logic [SEL_W-1:0] SEL_ALU    = 8'd2;
   localparam logic [SEL_W-1:0] SEL_STATUS = 8'd3;
   localparam logic [SEL_W-1:0] SEL_DMEM   = 8'd4;
   localparam logic [SEL_W-1:0] SEL_CTRL   = 8'd5;
   localparam logic [SEL_W-1:0] SEL_ALUCTL = 8'd6;
   localparam logic [SEL_W-1:0] SEL_PC     = 8'd7;
   localparam logic [SEL_W-1:0] SEL_RT     = 8'd8;
   localparam logic [SEL_W-1:0] SEL_EXC    = 8'd9;
   localparam logic [SEL_W-1:0] SEL_ALUB   = 8'd10;

   // One captured observation word as presented on the snapshot stream
   typedef struct packed {
      logic [SEL_W-1:0]  sel;
      logic [DATA_W-1:0] data;
      logic              last;
   } snap_word_t;

endpackage

// File: rtl/dbg_pulse_gen.sv
// Generates one CPU step-clock pulse: HALF cycles high then HALF cycles low.
// Ports:
//   clk   - board clock
//   rst   - synchronous active-high reset (drops the pulse immediately)
//   start - begin a pulse; pulse is high from the next cycle on
//   pulse - registered step clock
//   done  - registered; high during the final cycle of the current phase
module dbg_pulse_gen #(
   parameter int unsigned HALF = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic pulse,
   output logic done
);

   localparam int unsigned    CW        = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0]  HALF_LOAD = CW'(HALF - 1);

   logic          running;
   logic [CW-1:0] cnt;

   logic          running_n;
   logic          pulse_n;
   logic [CW-1:0] cnt_n;

   // Next phase/count; done looks ahead so it is high in the last phase cycle
   always_comb begin
      running_n = running;
      pulse_n   = pulse;
      cnt_n     = cnt;
      if (start) begin
         running_n = 1'b1;
         pulse_n   = 1'b1;
         cnt_n     = HALF_LOAD;
      end else if (running) begin
         if (cnt != '0) begin
            cnt_n = cnt - CW'(1);
         end else if (pulse) begin
            pulse_n = 1'b0;
            cnt_n   = HALF_LOAD;
         end else begin
            running_n = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         running <= 1'b0;
         pulse   <= 1'b0;
         cnt     <= '0;
         done    <= 1'b0;
      end else begin
         running <= running_n;
         pulse   <= pulse_n;
         cnt     <= cnt_n;
         done    <= running_n && (cnt_n == '0);
      end
   end

endmodule

// File: rtl/cpu_debug_sequencer.sv
// Debug-host sequencer for the single-cycle CPU: steps the CPU clock, loads
// the PC and sweeps the observation select, streaming captured words out.
// Ports:
//   CLOCK_50, SYS_reset              - board clock, sync active-high reset
//   cmd_valid/cmd_ready/cmd_op/cmd_pc - one-at-a-time host command port
//   cpu_clk/cpu_load/cpu_pc_load/cpu_output_sel - CPU debug inputs
//   obs_data                          - CPU observation bus
//   snap_valid/snap_ready/snap_sel/snap_data/snap_last - snapshot stream
//   busy                              - inverse of cmd_ready
module cpu_debug_sequencer
   import cpu_debug_pkg::*;
#(
   parameter int unsigned NUM_SEL          = 11,
   parameter int unsigned SETTLE_CYCLES    = 2,
   parameter int unsigned STEP_HALF_CYCLES = 4
) (
   input  logic              CLOCK_50,
   input  logic              SYS_reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [PC_W-1:0]   cmd_pc,
   output logic              cpu_clk,
   output logic              cpu_load,
   output logic [PC_W-1:0]   cpu_pc_load,
   output logic [SEL_W-1:0]  cpu_output_sel,
   input  logic [DATA_W-1:0] obs_data,
   output logic              snap_valid,
   input  logic              snap_ready,
   output logic [SEL_W-1:0]  snap_sel,
   output logic [DATA_W-1:0] snap_data,
   output logic              snap_last,
   output logic              busy
);

   localparam int unsigned      SC_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
   localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_SEL - 1);

   state_t            state;
   logic [OP_W-1:0]   op_q;
   logic [SEL_W-1:0]  k;
   logic [SC_W-1:0]   settle_cnt;
   snap_word_t        snap_q;

   logic              accept;
   logic              pulse_start;
   logic              pulse_done;

   assign accept      = cmd_valid && cmd_ready && (state == ST_IDLE);
   assign pulse_start = accept && (cmd_op != OP_SNAP);

   assign snap_sel  = snap_q.sel;
   assign snap_data = snap_q.data;
   assign snap_last = snap_q.last;

   // Step clock; its reset shares SYS_reset so a pulse is cut off at once
   dbg_pulse_gen #(
      .HALF (STEP_HALF_CYCLES)
   ) u_pulse_gen (
      .clk   (CLOCK_50),
      .rst   (SYS_reset),
      .start (pulse_start),
      .pulse (cpu_clk),
      .done  (pulse_done)
   );

   // Command sequencing, select sweep and snapshot handshake
   always_ff @(posedge CLOCK_50) begin
      if (SYS_reset) begin
         state          <= ST_IDLE;
         op_q           <= OP_STEP;
         k              <= '0;
         settle_cnt     <= '0;
         cmd_ready      <= 1'b1;
         busy           <= 1'b0;
         cpu_load       <= 1'b0;
         cpu_pc_load    <= '0;
         cpu_output_sel <= '0;
         snap_valid     <= 1'b0;
         snap_q         <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q      <= cmd_op;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (cmd_op == OP_LOAD) begin
                     cpu_load    <= 1'b1;
                     cpu_pc_load <= cmd_pc;
                  end
                  if (cmd_op == OP_SNAP) begin
                     k              <= '0;
                     cpu_output_sel <= '0;
                     settle_cnt     <= SETTLE_LOAD;
                     state          <= ST_SEL_SETTLE;
                  end else begin
                     state <= ST_PULSE_HI;
                  end
               end
            end

            ST_PULSE_HI: begin
               if (pulse_done) state <= ST_PULSE_LO;
            end

            ST_PULSE_LO: begin
               if (pulse_done) begin
                  cpu_load <= 1'b0;
                  if (op_q == OP_STEP_SNAP) begin
                     k              <= '0;
                     cpu_output_sel <= '0;
                     settle_cnt     <= SETTLE_LOAD;
                     state          <= ST_SEL_SETTLE;
                  end else begin
                     cmd_ready <= 1'b1;
                     busy      <= 1'b0;
                     state     <= ST_IDLE;
                  end
               end
            end

            ST_SEL_SETTLE: begin
               // Capture on the edge that closes the settle window
               if (settle_cnt == '0) begin
                  snap_q.sel  <= k;
                  snap_q.data <= obs_data;
                  snap_q.last <= (k == LAST_SEL);
                  snap_valid  <= 1'b1;
                  state       <= ST_EMIT;
               end else begin
                  settle_cnt <= settle_cnt - SC_W'(1);
               end
            end

            ST_EMIT: begin
               if (snap_ready) begin
                  snap_valid <= 1'b0;
                  if (snap_q.last) begin
                     cmd_ready <= 1'b1;
                     busy      <= 1'b0;
                     state     <= ST_IDLE;
                  end else begin
                     k              <= k + SEL_W'(1);
                     cpu_output_sel <= k + SEL_W'(1);
                     settle_cnt     <= SETTLE_LOAD;
                     state          <= ST_SEL_SETTLE;
                  end
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_debug_sequencer.sv
// Directed bench for cpu_debug_sequencer with default parameters
// (NUM_SEL=11, SETTLE_CYCLES=2, STEP_HALF_CYCLES=4). Cycle i is the i-th
// negedge sample after the edge that accepted the command.
module tb_cpu_debug_sequencer;
   import cpu_debug_pkg::*;

   logic        CLOCK_50;
   logic        SYS_reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_pc;
   logic        cpu_clk;
   logic        cpu_load;
   logic [7:0]  cpu_pc_load;
   logic [7:0]  cpu_output_sel;
   logic [31:0] obs_data;
   logic        snap_valid;
   logic        snap_ready;
   logic [7:0]  snap_sel;
   logic [31:0] snap_data;
   logic        snap_last;
   logic        busy;

   int vec;
   int errs;

   cpu_debug_sequencer dut (
      .CLOCK_50       (CLOCK_50),
      .SYS_reset      (SYS_reset),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .cmd_pc         (cmd_pc),
      .cpu_clk        (cpu_clk),
      .cpu_load       (cpu_load),
      .cpu_pc_load    (cpu_pc_load),
      .cpu_output_sel (cpu_output_sel),
      .obs_data       (obs_data),
      .snap_valid     (snap_valid),
      .snap_ready     (snap_ready),
      .snap_sel       (snap_sel),
      .snap_data      (snap_data),
      .snap_last      (snap_last),
      .busy           (busy)
   );

   // CPU observation model
   assign obs_data = 32'hA500_0000 | {24'h0, cpu_output_sel};

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Present a command, wait (bounded) for acceptance, return at cycle 1
   task automatic issue(input logic [1:0] op, input logic [7:0] pc);
      int n;
      @(negedge CLOCK_50);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_pc    = pc;
      n = 0;
      while (!cmd_ready && n < 300) begin
         @(negedge CLOCK_50);
         n++;
      end
      vec++;
      if (cmd_ready !== 1'b1) begin
         errs++;
         $display("FAIL issue_accept cmd_ready=%b required 1", cmd_ready);
      end
      @(negedge CLOCK_50);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      SYS_reset = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      vec++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errs++;
         $display("FAIL reset_ready cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
      end
      vec++;
      if (cpu_clk !== 1'b0 || cpu_load !== 1'b0 || cpu_pc_load !== 8'h00 || cpu_output_sel !== 8'h00) begin
         errs++;
         $display("FAIL reset_cpu clk=%b load=%b pc=%h sel=%h required 0/0/00/00",
                  cpu_clk, cpu_load, cpu_pc_load, cpu_output_sel);
      end
      vec++;
      if (snap_valid !== 1'b0 || snap_sel !== 8'h00 || snap_data !== 32'h0 || snap_last !== 1'b0) begin
         errs++;
         $display("FAIL reset_snap valid=%b sel=%h data=%h last=%b required 0/00/0/0",
                  snap_valid, snap_sel, snap_data, snap_last);
      end
      SYS_reset = 1'b0;
   endtask

   task automatic test_step();
      int   rises;
      logic prev;
      logic exp_clk;
      logic exp_rdy;
      issue(OP_STEP, 8'h00);
      rises = 0;
      prev  = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         if (i > 1) @(negedge CLOCK_50);
         exp_clk = (i <= 4);
         exp_rdy = (i == 9);
         vec++;
         if (cpu_clk !== exp_clk) begin
            errs++;
            $display("FAIL step_clk cycle %0d got %b want %b", i, cpu_clk, exp_clk);
         end
         vec++;
         if (cmd_ready !== exp_rdy || busy !== !exp_rdy) begin
            errs++;
            $display("FAIL step_ready cycle %0d ready=%b busy=%b want ready=%b", i, cmd_ready, busy, exp_rdy);
         end
         if (cpu_clk === 1'b1 && prev === 1'b0) rises++;
         prev = cpu_clk;
      end
      vec++;
      if (rises != 1) begin
         errs++;
         $display("FAIL step_rises got %0d want 1", rises);
      end
   endtask

   task automatic test_load();
      logic exp_load;
      issue(OP_LOAD, 8'h2C);
      for (int i = 1; i <= 9; i++) begin
         if (i > 1) @(negedge CLOCK_50);
         exp_load = (i <= 8);
         vec++;
         if (cpu_load !== exp_load || cpu_pc_load !== 8'h2C) begin
            errs++;
            $display("FAIL load_strobe cycle %0d load=%b pc=%h want %b/2c", i, cpu_load, cpu_pc_load, exp_load);
         end
         if (i <= 4) begin
            vec++;
            if (cpu_clk !== 1'b1) begin
               errs++;
               $display("FAIL load_clk_high cycle %0d got %b want 1", i, cpu_clk);
            end
         end
      end
   endtask

   task automatic test_snap();
      int   w;
      int   done_at;
      logic exp_v;
      snap_ready = 1'b1;
      issue(OP_SNAP, 8'h00);
      w = 0;
      done_at = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i > 1) @(negedge CLOCK_50);
         exp_v = ((i % 3) == 0) && (i <= 33);
         vec++;
         if (snap_valid !== exp_v || cpu_clk !== 1'b0) begin
            errs++;
            $display("FAIL snap_valid cycle %0d valid=%b clk=%b want %b/0", i, snap_valid, cpu_clk, exp_v);
         end
         if (snap_valid === 1'b1) begin
            vec++;
            if (snap_sel !== 8'(w) || snap_data !== (32'hA500_0000 | 32'(w)) || snap_last !== (w == 10)) begin
               errs++;
               $display("FAIL snap_word %0d sel=%h data=%h last=%b want %h/%h/%b",
                        w, snap_sel, snap_data, snap_last, 8'(w), 32'hA500_0000 | 32'(w), (w == 10));
            end
            w++;
         end
         if (cmd_ready === 1'b1 && done_at == 0) done_at = i;
      end
      vec++;
      if (w != 11 || done_at != 34) begin
         errs++;
         $display("FAIL snap_sweep words=%0d ready_at=%0d want 11/34", w, done_at);
      end
   endtask

   task automatic test_step_snap();
      int          w;
      logic        fin;
      logic        pv;
      logic        pr;
      logic [7:0]  hs;
      logic [31:0] hd;
      logic        hl;
      snap_ready = 1'b0;
      issue(OP_STEP_SNAP, 8'h00);
      w   = 0;
      fin = 1'b0;
      pv  = 1'b0;
      pr  = 1'b0;
      hs  = '0;
      hd  = '0;
      hl  = 1'b0;
      for (int i = 1; i <= 400 && !fin; i++) begin
         if (i > 1) @(negedge CLOCK_50);
         if (i == 1 || i == 5) begin
            vec++;
            if (cpu_clk !== (i == 1)) begin
               errs++;
               $display("FAIL stepsnap_clk cycle %0d got %b want %b", i, cpu_clk, (i == 1));
            end
         end
         if (i <= 8) begin
            vec++;
            if (snap_valid !== 1'b0) begin
               errs++;
               $display("FAIL stepsnap_early_valid cycle %0d got %b want 0", i, snap_valid);
            end
         end else if (pv && !pr) begin
            vec++;
            if (snap_valid !== 1'b1 || snap_sel !== hs || snap_data !== hd || snap_last !== hl) begin
               errs++;
               $display("FAIL stepsnap_stall cycle %0d valid=%b sel=%h data=%h last=%b want 1/%h/%h/%b",
                        i, snap_valid, snap_sel, snap_data, snap_last, hs, hd, hl);
            end
         end else if (snap_valid === 1'b1) begin
            vec++;
            if (snap_sel !== 8'(w) || snap_data !== (32'hA500_0000 | 32'(w)) || snap_last !== (w == 10)) begin
               errs++;
               $display("FAIL stepsnap_word %0d sel=%h data=%h last=%b", w, snap_sel, snap_data, snap_last);
            end
         end
         pv = snap_valid;
         hs = snap_sel;
         hd = snap_data;
         hl = snap_last;
         if (cmd_ready === 1'b1) fin = 1'b1;
         snap_ready = 1'($urandom_range(0, 1));
         pr = snap_ready;
         if (snap_valid === 1'b1 && snap_ready) w++;
      end
      vec++;
      if (!fin || w != 11) begin
         errs++;
         $display("FAIL stepsnap_total finished=%b words=%0d want 1/11", fin, w);
      end
      snap_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic exp_clk;
      logic exp_rdy;
      @(negedge CLOCK_50);
      cmd_valid = 1'b1;
      cmd_op    = OP_STEP;
      for (int i = 1; i <= 18; i++) begin
         @(negedge CLOCK_50);
         exp_clk = (i <= 4) || (i >= 10 && i <= 13);
         exp_rdy = (i == 9) || (i == 18);
         vec++;
         if (cpu_clk !== exp_clk || cmd_ready !== exp_rdy) begin
            errs++;
            $display("FAIL b2b cycle %0d clk=%b ready=%b want %b/%b", i, cpu_clk, cmd_ready, exp_clk, exp_rdy);
         end
         if (i == 10) cmd_valid = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      int n;
      // Reset during the high phase of a step
      issue(OP_STEP, 8'h00);
      @(negedge CLOCK_50);
      SYS_reset = 1'b1;
      @(negedge CLOCK_50);
      SYS_reset = 1'b0;
      vec++;
      if (cpu_clk !== 1'b0 || snap_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errs++;
         $display("FAIL rst_pulse clk=%b valid=%b ready=%b busy=%b want 0/0/1/0", cpu_clk, snap_valid, cmd_ready, busy);
      end
      issue(OP_STEP, 8'h00);
      for (int i = 1; i <= 9; i++) begin
         if (i > 1) @(negedge CLOCK_50);
         vec++;
         if (cpu_clk !== (i <= 4) || cmd_ready !== (i == 9)) begin
            errs++;
            $display("FAIL rst_pulse_after cycle %0d clk=%b ready=%b", i, cpu_clk, cmd_ready);
         end
      end
      // Reset while a snapshot word is stalled in EMIT
      snap_ready = 1'b0;
      issue(OP_SNAP, 8'h00);
      n = 0;
      while (snap_valid !== 1'b1 && n < 50) begin
         @(negedge CLOCK_50);
         n++;
      end
      @(negedge CLOCK_50);
      SYS_reset = 1'b1;
      @(negedge CLOCK_50);
      SYS_reset = 1'b0;
      vec++;
      if (cpu_clk !== 1'b0 || snap_valid !== 1'b0 || cmd_ready !== 1'b1 || cpu_output_sel !== 8'h00) begin
         errs++;
         $display("FAIL rst_emit clk=%b valid=%b ready=%b sel=%h want 0/0/1/00",
                  cpu_clk, snap_valid, cmd_ready, cpu_output_sel);
      end
      snap_ready = 1'b1;
      issue(OP_SNAP, 8'h00);
      repeat (2) @(negedge CLOCK_50);
      vec++;
      if (snap_valid !== 1'b1 || snap_sel !== 8'h00 || snap_data !== 32'hA500_0000 || snap_last !== 1'b0) begin
         errs++;
         $display("FAIL rst_emit_after valid=%b sel=%h data=%h last=%b want 1/00/a5000000/0",
                  snap_valid, snap_sel, snap_data, snap_last);
      end
      n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin
         @(negedge CLOCK_50);
         n++;
      end
      vec++;
      if (cmd_ready !== 1'b1) begin
         errs++;
         $display("FAIL rst_emit_finish ready=%b want 1", cmd_ready);
      end
   endtask

   initial begin
      vec        = 0;
      errs       = 0;
      SYS_reset  = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = 2'b00;
      cmd_pc     = 8'h00;
      snap_ready = 1'b0;
      test_reset();
      test_step();
      test_load();
      test_snap();
      test_step_snap();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
